wb_commit_scoreboard: RTL and testbench

- Writeback-side driver for the 2-way superscalar register file.
- Accepts paired completion results from the two execute lanes into a small pair-FIFO.
- Drains one pair per cycle onto the register file write ports (Wen1/Rd_addr1/write_data1, Wen2/Rd_addr2/write_data2), filtering x0 writes and same-cycle write-after-write (WAW) conflicts.
- Maintains a 32-bit pending-write scoreboard consumed by the issue stage.

---
 rtl/wb_commit_scoreboard_if.sv | 28 ++
 rtl/wb_commit_scoreboard.sv | 164 ++++++++++++++++
 tb/tb_wb_commit_scoreboard.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_scoreboard_if.sv
// Completion-pair handshake from the two execute lanes into the writeback scoreboard.
// Latency: none, plain wires.
// Backpressure: the consumer drives cmp_ready; a pair transfers when cmp_valid && cmp_ready.
interface wb_commit_scoreboard_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            cmp_valid;
  logic            cmp_ready;
  logic            cmp_wen1;
  logic [AW-1:0]   cmp_rd1;
  logic [XLEN-1:0] cmp_data1;
  logic            cmp_wen2;
  logic [AW-1:0]   cmp_rd2;
  logic [XLEN-1:0] cmp_data2;

  // Execute lanes produce completion pairs.
  modport master (
    output cmp_valid, cmp_wen1, cmp_rd1, cmp_data1, cmp_wen2, cmp_rd2, cmp_data2,
    input  cmp_ready
  );

  // Writeback scoreboard consumes completion pairs.
  modport slave (
    input  cmp_valid, cmp_wen1, cmp_rd1, cmp_data1, cmp_wen2, cmp_rd2, cmp_data2,
    output cmp_ready
  );
endinterface

// File: rtl/wb_commit_scoreboard.sv
// Writeback driver: buffers completion pairs, drains one pair per cycle onto two RF write ports, tracks pending writes.
// Latency: a pair pushed into an empty unstalled FIFO drives the write enables one edge later.
// Backpressure: cmp_ready drops when the pair-FIFO is full (a same-cycle pop does not help); wb_stall freezes draining.
module wb_commit_scoreboard #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid1,
  input  logic [AW-1:0]            iss_rd1,
  input  logic                     iss_valid2,
  input  logic [AW-1:0]            iss_rd2,
  wb_commit_scoreboard_if.slave    cmp,
  input  logic                     wb_stall,
  output logic                     Wen1,
  output logic [AW-1:0]            Rd_addr1,
  output logic [XLEN-1:0]          write_data1,
  output logic                     Wen2,
  output logic [AW-1:0]            Rd_addr2,
  output logic [XLEN-1:0]          write_data2,
  output logic [31:0]              busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic            wen1;
    logic [AW-1:0]   rd1;
    logic [XLEN-1:0] data1;
    logic            wen2;
    logic [AW-1:0]   rd2;
    logic [XLEN-1:0] data2;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          in_c;
  entry_t          head_c;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            wen1_q, wen1_d;
  logic            wen2_q, wen2_d;
  logic [AW-1:0]   rd1_q, rd1_d;
  logic [AW-1:0]   rd2_q, rd2_d;
  logic [XLEN-1:0] data1_q, data1_d;
  logic [XLEN-1:0] data2_q, data2_d;
  logic [31:0]     busy_q, busy_d;

  logic            ready_c;
  logic            push_c;
  logic            pop_c;
  logic            set_r;
  logic            clr_r;

  // Handshake decode: ready depends only on occupancy, and is held low throughout reset.
  always_comb begin
    ready_c = !rst && (count_q < CW'(DEPTH));
    push_c  = cmp.cmp_valid && ready_c;
    pop_c   = (count_q != '0) && !wb_stall;
    head_c  = mem_q[rd_ptr_q];
    in_c    = '{wen1: cmp.cmp_wen1, rd1: cmp.cmp_rd1, data1: cmp.cmp_data1,
                wen2: cmp.cmp_wen2, rd2: cmp.cmp_rd2, data2: cmp.cmp_data2};
  end

  assign cmp.cmp_ready = ready_c;

  // Pointer/occupancy next state and write-port loading; x0 and same-pair WAW are filtered, lane 2 is younger and wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wen1_d   = 1'b0;
    wen2_d   = 1'b0;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      wen2_d   = head_c.wen2 && (head_c.rd2 != '0);
      wen1_d   = head_c.wen1 && (head_c.rd1 != '0) &&
                 !(head_c.wen2 && (head_c.rd2 == head_c.rd1));
      rd1_d    = head_c.rd1;
      rd2_d    = head_c.rd2;
      data1_d  = head_c.data1;
      data2_d  = head_c.data2;
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pending-write scoreboard: a new issue beats a retiring write to the same register; x0 never pends.
  always_comb begin
    busy_d = busy_q;
    set_r  = 1'b0;
    clr_r  = 1'b0;
    for (int r = 1; r < 32; r++) begin
      set_r = (iss_valid1 && (iss_rd1 == AW'(r))) || (iss_valid2 && (iss_rd2 == AW'(r)));
      clr_r = (wen1_d && (rd1_d == AW'(r))) || (wen2_d && (rd2_d == AW'(r)));
      if (set_r) begin
        busy_d[r] = 1'b1;
      end else if (clr_r) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset discards buffered pairs and clears the write ports and scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wen1_q   <= 1'b0;
      wen2_q   <= 1'b0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wen1_q   <= wen1_d;
      wen2_q   <= wen2_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      busy_q   <= busy_d;
    end
  end

  // Pair storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_c;
    end
  end

  assign Wen1        = wen1_q;
  assign Wen2        = wen2_q;
  assign Rd_addr1    = rd1_q;
  assign Rd_addr2    = rd2_q;
  assign write_data1 = data1_q;
  assign write_data2 = data2_q;
  assign busy        = busy_q;
  assign count       = count_q;

endmodule

// File: tb/tb_wb_commit_scoreboard.sv
// Self-checking bench for wb_commit_scoreboard: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model predicts register-file port state one edge after each input cycle.
// Backpressure: model mirrors FIFO-full refusal and wb_stall freezes.
module tb_wb_commit_scoreboard;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int AW    = 5;

  typedef struct packed {
    logic            wen1;
    logic [AW-1:0]   rd1;
    logic [XLEN-1:0] d1;
    logic            wen2;
    logic [AW-1:0]   rd2;
    logic [XLEN-1:0] d2;
  } pair_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid1, iss_valid2, wb_stall;
  logic [AW-1:0]   iss_rd1, iss_rd2;
  logic            Wen1, Wen2;
  logic [AW-1:0]   Rd_addr1, Rd_addr2;
  logic [XLEN-1:0] write_data1, write_data2;
  logic [31:0]     busy;
  logic [2:0]      count;

  wb_commit_scoreboard_if #(.XLEN(XLEN), .AW(AW)) cmp_if ();

  wb_commit_scoreboard #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .iss_valid1(iss_valid1), .iss_rd1(iss_rd1),
    .iss_valid2(iss_valid2), .iss_rd2(iss_rd2),
    .cmp(cmp_if), .wb_stall(wb_stall),
    .Wen1(Wen1), .Rd_addr1(Rd_addr1), .write_data1(write_data1),
    .Wen2(Wen2), .Rd_addr2(Rd_addr2), .write_data2(write_data2),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the FIFO is a queue, the write ports are plain variables.
  pair_t           m_q[$];
  logic            m_wen1, m_wen2;
  logic [AW-1:0]   m_rd1, m_rd2;
  logic [XLEN-1:0] m_d1, m_d2;
  logic [31:0]     m_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pair_t mk(input logic w1, input logic [AW-1:0] r1, input logic [XLEN-1:0] d1,
                               input logic w2, input logic [AW-1:0] r2, input logic [XLEN-1:0] d2);
    pair_t p;
    p = '{wen1: w1, rd1: r1, d1: d1, wen2: w2, rd2: r2, d2: d2};
    return p;
  endfunction

  function automatic pair_t rnd_pair();
    return mk(1'(($urandom_range(0, 3)) != 0), AW'($urandom_range(0, 7)), {$urandom, $urandom},
              1'(($urandom_range(0, 3)) != 0), AW'($urandom_range(0, 7)), {$urandom, $urandom});
  endfunction

  // One clock cycle: drive after the falling edge, predict, check just after the rising edge.
  task automatic cycle(input bit v, input pair_t p, input bit st,
                       input bit iv1, input logic [AW-1:0] ir1,
                       input bit iv2, input logic [AW-1:0] ir2);
    bit rdy, push, pop;
    pair_t e;
    logic [31:0] wmask, imask;
    cmp_if.cmp_valid = v;
    cmp_if.cmp_wen1  = p.wen1;
    cmp_if.cmp_rd1   = p.rd1;
    cmp_if.cmp_data1 = p.d1;
    cmp_if.cmp_wen2  = p.wen2;
    cmp_if.cmp_rd2   = p.rd2;
    cmp_if.cmp_data2 = p.d2;
    wb_stall   = st;
    iss_valid1 = iv1;
    iss_rd1    = ir1;
    iss_valid2 = iv2;
    iss_rd2    = ir2;
    #1;
    rdy = m_q.size() < DEPTH;
    chk("cmp_ready", {63'd0, cmp_if.cmp_ready}, {63'd0, rdy});
    push   = v && rdy;
    pop    = (m_q.size() > 0) && !st;
    m_wen1 = 1'b0;
    m_wen2 = 1'b0;
    if (pop) begin
      e      = m_q.pop_front();
      m_wen2 = e.wen2 && (e.rd2 != 0);
      m_wen1 = e.wen1 && (e.rd1 != 0) && !(e.wen2 && (e.rd2 == e.rd1));
      m_rd1  = e.rd1;
      m_rd2  = e.rd2;
      m_d1   = e.d1;
      m_d2   = e.d2;
    end
    if (push) m_q.push_back(p);
    wmask = '0;
    if (m_wen1) wmask[m_rd1] = 1'b1;
    if (m_wen2) wmask[m_rd2] = 1'b1;
    imask = '0;
    if (iv1) imask[ir1] = 1'b1;
    if (iv2) imask[ir2] = 1'b1;
    m_busy = ((m_busy & ~wmask) | imask) & ~32'h1;
    @(posedge clk);
    #1;
    chk("Wen1", {63'd0, Wen1}, {63'd0, m_wen1});
    chk("Wen2", {63'd0, Wen2}, {63'd0, m_wen2});
    chk("Rd_addr1", 64'(Rd_addr1), 64'(m_rd1));
    chk("Rd_addr2", 64'(Rd_addr2), 64'(m_rd2));
    chk("write_data1", write_data1, m_d1);
    chk("write_data2", write_data2, m_d2);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("count_le_depth", {63'd0, (count <= 3'(DEPTH))}, 64'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic push_only(input pair_t p, input bit st);
    cycle(1'b1, p, st, 1'b0, '0, 1'b0, '0);
  endtask

  // Asynchronous reset asserted between edges; effects must be visible before the next edge.
  task automatic do_reset();
    cmp_if.cmp_valid = 1'b0;
    wb_stall   = 1'b0;
    iss_valid1 = 1'b0;
    iss_valid2 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_Wen1", {63'd0, Wen1}, 64'd0);
    chk("rst_Wen2", {63'd0, Wen2}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_addr", {54'd0, Rd_addr1, Rd_addr2}, 64'd0);
    chk("rst_data", write_data1 | write_data2, 64'd0);
    chk("rst_ready", {63'd0, cmp_if.cmp_ready}, 64'd0);
    m_q.delete();
    m_wen1 = 1'b0; m_wen2 = 1'b0;
    m_rd1 = '0; m_rd2 = '0; m_d1 = '0; m_d2 = '0;
    m_busy = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_ready", {63'd0, cmp_if.cmp_ready}, 64'd1);
  endtask

  initial begin
    int r1, r2;
    bit iv1, iv2;
    rst = 1'b1;
    wb_stall = 1'b0;
    iss_valid1 = 1'b0; iss_rd1 = '0;
    iss_valid2 = 1'b0; iss_rd2 = '0;
    cmp_if.cmp_valid = 1'b0;
    cmp_if.cmp_wen1 = 1'b0; cmp_if.cmp_rd1 = '0; cmp_if.cmp_data1 = '0;
    cmp_if.cmp_wen2 = 1'b0; cmp_if.cmp_rd2 = '0; cmp_if.cmp_data2 = '0;
    @(negedge clk);
    do_reset();

    // Basic pair: written one edge after the push, enables pulse for a single cycle.
    push_only(mk(1'b1, 5'd5, 64'h11, 1'b1, 5'd6, 64'h22), 1'b0);
    idle(1);
    chk("t1_wen1", {63'd0, Wen1}, 64'd1);
    chk("t1_rd1", 64'(Rd_addr1), 64'd5);
    chk("t1_d1", write_data1, 64'h11);
    chk("t1_wen2", {63'd0, Wen2}, 64'd1);
    chk("t1_rd2", 64'(Rd_addr2), 64'd6);
    chk("t1_d2", write_data2, 64'h22);
    idle(1);
    chk("t1_pulse", {62'd0, Wen1, Wen2}, 64'd0);

    // Same-pair WAW: younger lane wins. Then an x0 destination is dropped.
    push_only(mk(1'b1, 5'd9, 64'hA, 1'b1, 5'd9, 64'hB), 1'b0);
    idle(1);
    chk("waw_wen1", {63'd0, Wen1}, 64'd0);
    chk("waw_wen2", {63'd0, Wen2}, 64'd1);
    chk("waw_d2", write_data2, 64'hB);
    push_only(mk(1'b1, 5'd0, 64'h33, 1'b0, 5'd4, 64'h44), 1'b0);
    idle(1);
    chk("x0_wen1", {63'd0, Wen1}, 64'd0);

    // Fill under stall; a fifth offer is refused; release drains in order.
    for (int i = 0; i < 4; i++) push_only(mk(1'b1, AW'(i + 1), 64'(100 + i), 1'b0, '0, '0), 1'b1);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", {63'd0, cmp_if.cmp_ready}, 64'd0);
    push_only(mk(1'b1, 5'd20, 64'hDEAD, 1'b0, '0, '0), 1'b1);
    chk("full_refused", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("drain_order", write_data1, 64'(100 + i));
    end
    chk("drain_empty", 64'(count), 64'd0);
    chk("drain_ready", {63'd0, cmp_if.cmp_ready}, 64'd1);

    // Scoreboard: issue sets; issue beats a same-edge retire; a lone retire clears.
    cycle(1'b0, '0, 1'b0, 1'b1, 5'd7, 1'b0, '0);
    chk("busy7_set", {63'd0, busy[7]}, 64'd1);
    push_only(mk(1'b1, 5'd7, 64'h77, 1'b0, '0, '0), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 5'd7, 1'b0, '0);
    chk("busy7_set_wins", {63'd0, busy[7]}, 64'd1);
    push_only(mk(1'b0, 5'd3, 64'h1, 1'b1, 5'd7, 64'h78), 1'b0);
    idle(1);
    chk("busy7_clr", {63'd0, busy[7]}, 64'd0);

    // Randomized traffic with stalls; exercises pointer wrap and full/empty edges.
    for (int n = 0; n < 400; n++) begin
      r1  = $urandom_range(1, 7);
      r2  = $urandom_range(1, 7);
      iv1 = ($urandom_range(0, 3) == 0) && !m_busy[r1];
      iv2 = ($urandom_range(0, 3) == 0) && !m_busy[r2];
      cycle(1'($urandom_range(0, 2) != 0), rnd_pair(), 1'($urandom_range(0, 9) < 3),
            iv1, AW'(r1), iv2, AW'(r2));
    end

    // Reset mid-drain with three entries queued and registers pending.
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b1, 5'd12, 1'b1, 5'd13);
    for (int i = 0; i < 4; i++) push_only(mk(1'b1, AW'(i + 2), 64'(200 + i), 1'b1, 5'd14, 64'h5), 1'b1);
    idle(1);
    chk("pre_rst_count", 64'(count), 64'd3);
    chk("pre_rst_wen", {63'd0, Wen1}, 64'd1);
    do_reset();
    idle(4);
    chk("post_rst_no_stale", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
